// File: rtl/iob_ethmac_mem_arbiter.sv
// Round-robin arbiter that shares one IOb memory port between the MAC DMA (port 0)
// and a second IOb master (port 1). It allows one outstanding transaction and aborts it on timeout.
module iob_ethmac_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 1024,
  parameter int TIMEOUT_W = 11
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                s0_valid_i,
  input  logic [ADDR_W-1:0]   s0_addr_i,
  input  logic [DATA_W-1:0]   s0_wdata_i,
  input  logic [DATA_W/8-1:0] s0_wstrb_i,
  output logic [DATA_W-1:0]   s0_rdata_o,
  output logic                s0_ready_o,
  output logic                s0_err_o,
  input  logic                s1_valid_i,
  input  logic [ADDR_W-1:0]   s1_addr_i,
  input  logic [DATA_W-1:0]   s1_wdata_i,
  input  logic [DATA_W/8-1:0] s1_wstrb_i,
  output logic [DATA_W-1:0]   s1_rdata_o,
  output logic                s1_ready_o,
  output logic                s1_err_o,
  output logic                m_valid_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic                m_ready_i,
  input  logic                m_err_i,
  output logic                grant_o,
  output logic                busy_o,
  output logic                timeout_o
);

  localparam bit TMO_EN = (TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic                 prio;
  logic                 grant;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 req, pick, done, expire, finish;
  logic [DATA_W-1:0]    resp_rdata;
  logic                 resp_err;

  always_comb begin
    req       = s0_valid_i | s1_valid_i;
    // A lone requester wins outright; prio only decides a tie.
    pick      = (s0_valid_i & s1_valid_i) ? prio : s1_valid_i;
    done      = (state == BUSY) & m_ready_i;
    expire    = TMO_EN & (state == BUSY) & ~m_ready_i & (cnt == TMO_LAST);
    finish    = done | expire;
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = BUSY;
      BUSY:    if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      prio      <= 1'b0;
      grant     <= 1'b0;
      cnt       <= '0;
      m_addr_o  <= '0;
      m_wdata_o <= '0;
      m_wstrb_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        grant     <= pick;
        m_addr_o  <= pick ? s1_addr_i  : s0_addr_i;
        m_wdata_o <= pick ? s1_wdata_i : s0_wdata_i;
        m_wstrb_o <= pick ? s1_wstrb_i : s0_wstrb_i;
        cnt       <= '0;
      end else if (state == BUSY) begin
        if (finish) prio <= ~grant;
        else        cnt  <= cnt + TIMEOUT_W'(1);
      end
    end
  end

  // Response routing: a timeout reports an error with zero data, and a real completion wins a tie.
  always_comb begin
    resp_rdata = done ? m_rdata_i : '0;
    resp_err   = done ? m_err_i : expire;
    s0_ready_o = finish & ~grant;
    s1_ready_o = finish & grant;
    s0_rdata_o = grant ? '0 : resp_rdata;
    s1_rdata_o = grant ? resp_rdata : '0;
    s0_err_o   = ~grant & resp_err;
    s1_err_o   = grant & resp_err;
  end

  assign m_valid_o = (state == BUSY);
  assign busy_o    = (state == BUSY);
  assign grant_o   = grant;
  assign timeout_o = expire;

endmodule

// File: tb/tb_iob_ethmac_mem_arbiter.sv
// Bench for iob_ethmac_mem_arbiter. It uses directed scenarios and a transaction-level
// reference model, and compares the DUT with the model on every falling edge.
module tb_iob_ethmac_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 16;
  localparam int TW  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          s0_valid, s1_valid;
  logic [AW-1:0] s0_addr, s1_addr;
  logic [DW-1:0] s0_wdata, s1_wdata;
  logic [SW-1:0] s0_wstrb, s1_wstrb;
  logic [DW-1:0] s0_rdata, s1_rdata;
  logic          s0_ready, s1_ready, s0_err, s1_err;
  logic          m_valid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic [DW-1:0] m_rdata;
  logic          m_ready, m_err;
  logic          grant, busy, timeout;

  iob_ethmac_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .TIMEOUT_W(TW)) dut (
    .clk_i(clk), .rst_i(rst),
    .s0_valid_i(s0_valid), .s0_addr_i(s0_addr), .s0_wdata_i(s0_wdata), .s0_wstrb_i(s0_wstrb),
    .s0_rdata_o(s0_rdata), .s0_ready_o(s0_ready), .s0_err_o(s0_err),
    .s1_valid_i(s1_valid), .s1_addr_i(s1_addr), .s1_wdata_i(s1_wdata), .s1_wstrb_i(s1_wstrb),
    .s1_rdata_o(s1_rdata), .s1_ready_o(s1_ready), .s1_err_o(s1_err),
    .m_valid_o(m_valid), .m_addr_o(m_addr), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb),
    .m_rdata_i(m_rdata), .m_ready_i(m_ready), .m_err_i(m_err),
    .grant_o(grant), .busy_o(busy), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the transaction in flight, the memory request it carries, and which port wins the next tie.
  bit          mdl_live = 1'b0;
  bit          mdl_busy = 1'b0;
  bit          mdl_port = 1'b0;
  bit          mdl_tie  = 1'b0;
  int          mdl_beat = 0;
  logic [AW-1:0] mdl_addr  = '0;
  logic [DW-1:0] mdl_wdata = '0;
  logic [SW-1:0] mdl_wstrb = '0;
  wire         mdl_pick = (s0_valid && s1_valid) ? mdl_tie : s1_valid;

  always @(posedge clk) begin
    mdl_live <= 1'b1;
    if (rst) begin
      mdl_busy <= 1'b0; mdl_port <= 1'b0; mdl_tie <= 1'b0; mdl_beat <= 0;
      mdl_addr <= '0; mdl_wdata <= '0; mdl_wstrb <= '0;
    end else if (!mdl_busy) begin
      if (s0_valid || s1_valid) begin
        mdl_busy  <= 1'b1;
        mdl_port  <= mdl_pick;
        mdl_beat  <= 1;
        mdl_addr  <= mdl_pick ? s1_addr  : s0_addr;
        mdl_wdata <= mdl_pick ? s1_wdata : s0_wdata;
        mdl_wstrb <= mdl_pick ? s1_wstrb : s0_wstrb;
      end
    end else if (m_ready || mdl_beat == TMO) begin
      mdl_busy <= 1'b0;
      mdl_tie  <= !mdl_port;
    end else begin
      mdl_beat <= mdl_beat + 1;
    end
  end

  int glog[$];

  always @(negedge clk) begin
    if (mdl_live) begin
      bit fin_ok, fin_to, fin;
      logic [DW-1:0] rd;
      fin_ok = mdl_busy && m_ready;
      fin_to = mdl_busy && !m_ready && mdl_beat == TMO;
      fin    = fin_ok || fin_to;
      rd     = fin_ok ? m_rdata : '0;
      chk("m_valid", m_valid, mdl_busy);
      chk("busy", busy, mdl_busy);
      chk("grant", grant, mdl_port);
      chk("m_addr", m_addr, mdl_addr);
      chk("m_wdata", m_wdata, mdl_wdata);
      chk("m_wstrb", m_wstrb, mdl_wstrb);
      chk("s0_ready", s0_ready, fin && !mdl_port);
      chk("s1_ready", s1_ready, fin && mdl_port);
      chk("s0_rdata", s0_rdata, mdl_port ? '0 : rd);
      chk("s1_rdata", s1_rdata, mdl_port ? rd : '0);
      chk("s0_err", s0_err, !mdl_port && (fin_ok ? m_err : fin_to));
      chk("s1_err", s1_err, mdl_port && (fin_ok ? m_err : fin_to));
      chk("timeout", timeout, fin_to);
      if (s0_ready) glog.push_back(0);
      if (s1_ready) glog.push_back(1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_valid = 0; s1_valid = 0; s0_addr = '0; s1_addr = '0;
    s0_wdata = '0; s1_wdata = '0; s0_wstrb = '0; s1_wstrb = '0;
    m_rdata = '0; m_ready = 0; m_err = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt, rdy_cnt, to_cnt;
    rst = 1;
    clear_inputs();
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_m_addr", m_addr, 0);

    // Single read on port 0
    s0_valid = 1; s0_addr = 32'h100;
    tick();
    m_ready = 1; m_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_s0_ready", s0_ready, 1);
    chk("t1_s0_rdata", s0_rdata, 32'hDEADBEEF);
    chk("t1_s1_ready", s1_ready, 0);
    tick();
    s0_valid = 0; m_ready = 0;
    @(negedge clk);
    chk("t1_m_valid_drop", m_valid, 0);

    // Both ports stream writes; memory always ready
    do_reset();
    glog.delete();
    s0_valid = 1; s0_addr = 32'h200; s0_wdata = 32'h1111_0000; s0_wstrb = 4'hF;
    s1_valid = 1; s1_addr = 32'h300; s1_wdata = 32'h2222_0000; s1_wstrb = 4'hF;
    m_ready = 1; m_rdata = 32'h55;
    repeat (16) tick();
    clear_inputs();
    chk("t2_txn_count", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++)
      chk($sformatf("t2_grant_seq%0d", i), glog[i], i % 2);

    // Port 1 write stalled 5 cycles
    do_reset();
    s1_valid = 1; s1_addr = 32'h400; s1_wdata = 32'hA5A5_5A5A; s1_wstrb = 4'h3;
    busy_cnt = 0; rdy_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      m_ready = (k == 6);
      if (k == 7) s1_valid = 0;
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        chk("t3_addr_stable", m_addr, 32'h400);
        chk("t3_wdata_stable", m_wdata, 32'hA5A5_5A5A);
        chk("t3_wstrb_stable", m_wstrb, 4'h3);
      end
      if (s1_ready) rdy_cnt++;
      tick();
    end
    chk("t3_busy_cycles", busy_cnt, 6);
    chk("t3_ready_pulses", rdy_cnt, 1);
    clear_inputs();

    // Timeout with memory silent, then a late response in IDLE
    do_reset();
    s0_valid = 1; s0_addr = 32'h500;
    to_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      m_ready = (k == 17);
      if (k == 17) s0_valid = 0;
      @(negedge clk);
      if (timeout) to_cnt++;
      if (k == 16) begin
        chk("t4_s0_ready", s0_ready, 1);
        chk("t4_s0_err", s0_err, 1);
        chk("t4_timeout", timeout, 1);
      end
      if (k == 17 || k == 18) begin
        chk("t4_late_s0_ready", s0_ready, 0);
        chk("t4_late_s1_ready", s1_ready, 0);
      end
      tick();
    end
    chk("t4_timeout_pulses", to_cnt, 1);
    clear_inputs();

    // Memory error on a port 1 read
    do_reset();
    s1_valid = 1; s1_addr = 32'h600;
    tick();
    m_ready = 1; m_err = 1; m_rdata = 32'h1234;
    @(negedge clk);
    chk("t5_s1_ready", s1_ready, 1);
    chk("t5_s1_err", s1_err, 1);
    chk("t5_timeout", timeout, 0);
    chk("t5_s0_ready", s0_ready, 0);
    tick();
    clear_inputs();

    // Reset in the 3rd BUSY cycle of a back-to-back port 0 request
    do_reset();
    s0_valid = 1; s0_addr = 32'h700;
    tick();
    m_ready = 1;
    tick();
    m_ready = 0;
    tick();
    tick();
    tick();
    rst = 1;
    @(negedge clk);
    chk("t6_busy3", busy, 1);
    chk("t6_no_ready_rst", s0_ready, 0);
    tick();
    rst = 0;
    s0_valid = 1; s1_valid = 1; s1_addr = 32'h800;
    @(negedge clk);
    chk("t6_m_valid", m_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_no_ready_after", s0_ready, 0);
    tick();
    @(negedge clk);
    chk("t6_prio_reset", grant, 0);
    tick();
    m_ready = 1; s0_valid = 0; s1_valid = 0;
    tick();
    clear_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
